// File: rtl/mpc_constraint_slack_check.sv
// mpc_constraint_slack_check
// Streams the constraint vector h[] and the product gu[] = G*U. For each row it
// computes the saturated slack s = h - gu, writes s to the slack RAM, and
// accumulates the results the QP active-set update needs.
//
// Ports:
//   ap_clk, ap_rst_n         clock, synchronous active-low reset
//   ap_start/done/idle/ready block-level handshake
//   h_*, gu_*                read ports, 1-cycle read latency
//   s_*                      slack RAM write port
//   active_mask, n_active    rows with s <= TOL, and how many of them
//   max_viol, viol_flag      largest shortfall (-s) and whether it is nonzero
module mpc_constraint_slack_check #(
    parameter int N_CON  = 20,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter logic signed [DATA_W-1:0] TOL = 32'sd66
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] h_address0,
    output logic              h_ce0,
    input  logic [DATA_W-1:0] h_q0,
    output logic [ADDR_W-1:0] gu_address0,
    output logic              gu_ce0,
    input  logic [DATA_W-1:0] gu_q0,
    output logic [ADDR_W-1:0] s_address0,
    output logic              s_ce0,
    output logic              s_we0,
    output logic [DATA_W-1:0] s_d0,
    output logic [N_CON-1:0]  active_mask,
    output logic [ADDR_W-1:0] n_active,
    output logic [DATA_W-1:0] max_viol,
    output logic              viol_flag
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(N_CON - 1);
    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [N_CON-1:0]  ONE   = {{(N_CON-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   r_q, r_d;
    logic                wr_vld_q, wr_vld_d;   // data stage holds a valid row
    logic [ADDR_W-1:0]   wr_idx_q, wr_idx_d;   // row index of that data
    logic [N_CON-1:0]    active_mask_q, active_mask_d;
    logic [ADDR_W-1:0]   n_active_q, n_active_d;
    logic [DATA_W-1:0]   max_viol_q, max_viol_d;
    logic                viol_flag_q, viol_flag_d;

    logic                start_acc;
    logic signed [DATA_W:0] diff;
    logic [DATA_W-1:0]   s_sat;
    logic [DATA_W-1:0]   viol;
    logic                row_active;

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q       <= IDLE;
            r_q           <= '0;
            wr_vld_q      <= 1'b0;
            wr_idx_q      <= '0;
            active_mask_q <= '0;
            n_active_q    <= '0;
            max_viol_q    <= '0;
            viol_flag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            wr_vld_q      <= wr_vld_d;
            wr_idx_q      <= wr_idx_d;
            active_mask_q <= active_mask_d;
            n_active_q    <= n_active_d;
            max_viol_q    <= max_viol_d;
            viol_flag_q   <= viol_flag_d;
        end
    end

    assign start_acc = (state_q == IDLE) && ap_start;

    // Next state and read index
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        case (state_q)
            IDLE:  if (ap_start) begin
                       state_d = RUN;
                       r_d     = '0;
                   end
            RUN:   if (r_q == LAST) state_d = DRAIN;
                   else             r_d     = r_q + 1'b1;
            DRAIN: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs of the FSM
    always_comb begin
        ap_idle     = (state_q == IDLE);
        ap_done     = (state_q == DONE);
        ap_ready    = (state_q == DONE);
        h_ce0       = (state_q == RUN);
        gu_ce0      = (state_q == RUN);
        h_address0  = (state_q == RUN) ? r_q : '0;
        gu_address0 = (state_q == RUN) ? r_q : '0;
    end

    // Data stage: one cycle behind the read issue
    always_comb begin
        wr_vld_d = (state_q == RUN);
        wr_idx_d = r_q;

        diff = {h_q0[DATA_W-1], h_q0} - {gu_q0[DATA_W-1], gu_q0};
        // The two top bits disagree only when the result overflows DATA_W.
        if (diff[DATA_W] != diff[DATA_W-1])
            s_sat = diff[DATA_W] ? S_MIN : S_MAX;
        else
            s_sat = diff[DATA_W-1:0];

        row_active = ($signed(s_sat) <= TOL);

        // Negating the most negative value would wrap, so clamp it.
        if (!s_sat[DATA_W-1]) viol = '0;
        else if (s_sat == S_MIN) viol = S_MAX;
        else viol = -s_sat;

        s_ce0      = wr_vld_q;
        s_we0      = wr_vld_q;
        s_address0 = wr_vld_q ? wr_idx_q : '0;
        s_d0       = wr_vld_q ? s_sat : '0;

        active_mask_d = active_mask_q;
        n_active_d    = n_active_q;
        max_viol_d    = max_viol_q;
        viol_flag_d   = viol_flag_q;
        if (start_acc) begin
            active_mask_d = '0;
            n_active_d    = '0;
            max_viol_d    = '0;
            viol_flag_d   = 1'b0;
        end else if (wr_vld_q) begin
            if (row_active) begin
                active_mask_d = active_mask_q | (ONE << wr_idx_q);
                n_active_d    = n_active_q + 1'b1;
            end
            // Both operands are non-negative, so an unsigned compare is exact.
            if (viol > max_viol_q) max_viol_d = viol;
            viol_flag_d = (max_viol_d != '0);
        end
    end

    assign active_mask = active_mask_q;
    assign n_active    = n_active_q;
    assign max_viol    = max_viol_q;
    assign viol_flag   = viol_flag_q;

endmodule

// File: tb/tb_mpc_constraint_slack_check.sv
module tb_mpc_constraint_slack_check;
    localparam int N = 20;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n, ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  h_address0, gu_address0, s_address0;
    logic        h_ce0, gu_ce0, s_ce0, s_we0;
    logic [31:0] h_q0, gu_q0, s_d0, max_viol;
    logic [19:0] active_mask;
    logic [4:0]  n_active;
    logic        viol_flag;

    always #5 ap_clk = ~ap_clk;

    mpc_constraint_slack_check dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .h_address0(h_address0), .h_ce0(h_ce0), .h_q0(h_q0),
        .gu_address0(gu_address0), .gu_ce0(gu_ce0), .gu_q0(gu_q0),
        .s_address0(s_address0), .s_ce0(s_ce0), .s_we0(s_we0), .s_d0(s_d0),
        .active_mask(active_mask), .n_active(n_active),
        .max_viol(max_viol), .viol_flag(viol_flag)
    );

    logic [31:0] h_mem [N];
    logic [31:0] gu_mem[N];
    logic [31:0] s_mem [N];

    // RAM models, 1-cycle read latency
    always @(posedge ap_clk) begin
        if (h_ce0 && h_address0 < N)   h_q0  <= h_mem[h_address0];
        if (gu_ce0 && gu_address0 < N) gu_q0 <= gu_mem[gu_address0];
    end

    int cyc = 0, nwr = 0, done_cnt = 0, bad_addr = 0, rdy_bad = 0;
    always @(negedge ap_clk) begin
        cyc++;
        if (s_ce0 && s_we0) begin
            if (s_address0 < N) s_mem[s_address0] = s_d0;
            nwr++;
        end
        if ((h_ce0 && h_address0 >= N) || (gu_ce0 && gu_address0 >= N) ||
            (s_ce0 && s_address0 >= N)) bad_addr++;
        if (ap_done) done_cnt++;
        if (ap_ready !== ap_done) rdy_bad++;
    end

    typedef struct {
        logic [N-1:0][31:0] h;
        logic [N-1:0][31:0] gu;
        logic [19:0]        mask;
        logic [31:0]        n;
        logic [31:0]        mv;
        logic               flag;
        int                 r0, r1;
        logic [31:0]        s0, s1;
    } vec_t;

    vec_t vec[4];
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(negedge ap_clk);
        #1;
    endtask

    task automatic load(input int k);
        for (int i = 0; i < N; i++) begin
            h_mem[i]  = vec[k].h[i];
            gu_mem[i] = vec[k].gu[i];
            s_mem[i]  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic run_vec(input int k);
        int st, base, lat;
        load(k);
        base = nwr;
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(posedge ap_clk);
        st = cyc;
        #1 ap_start = 1'b0;
        lat = -1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (ap_done) begin lat = cyc - st; break; end
        end
        chk($sformatf("v%0d latency", k), lat, 22);
        chk($sformatf("v%0d writes", k), nwr - base, N);
        chk($sformatf("v%0d mask", k), {12'd0, active_mask}, {12'd0, vec[k].mask});
        chk($sformatf("v%0d n_active", k), {27'd0, n_active}, vec[k].n);
        chk($sformatf("v%0d max_viol", k), max_viol, vec[k].mv);
        chk($sformatf("v%0d viol_flag", k), {31'd0, viol_flag}, {31'd0, vec[k].flag});
        chk($sformatf("v%0d s[%0d]", k, vec[k].r0), s_mem[vec[k].r0], vec[k].s0);
        chk($sformatf("v%0d s[%0d]", k, vec[k].r1), s_mem[vec[k].r1], vec[k].s1);
        tick();
        chk($sformatf("v%0d idle after", k), {31'd0, ap_idle}, 32'd1);
    endtask

    initial begin
        int d1, d2, base, dbase;

        // 0: builder default, rows 0..15 at zero slack
        for (int i = 0; i < N; i++) begin
            vec[0].h[i] = (i >= 16) ? 32'd655360 : 32'd0;
            vec[0].gu[i] = 32'd0;
        end
        vec[0].mask = 20'h0FFFF; vec[0].n = 16; vec[0].mv = 0; vec[0].flag = 0;
        vec[0].r0 = 16; vec[0].s0 = 32'd655360; vec[0].r1 = 0; vec[0].s1 = 32'd0;

        // 1: one violated row
        for (int i = 0; i < N; i++) begin
            vec[1].h[i] = 32'd655360; vec[1].gu[i] = 32'd0;
        end
        vec[1].gu[3] = 32'd720896;
        vec[1].mask = 20'h00008; vec[1].n = 1; vec[1].mv = 32'd65536; vec[1].flag = 1;
        vec[1].r0 = 3; vec[1].s0 = 32'hFFFF_0000; vec[1].r1 = 0; vec[1].s1 = 32'd655360;

        // 2: tolerance edge and running max
        for (int i = 0; i < N; i++) begin
            vec[2].h[i] = 32'd655360; vec[2].gu[i] = 32'd0;
        end
        vec[2].gu[5] = 32'd655360 - 32'd66;
        vec[2].gu[6] = 32'd655360 - 32'd67;
        vec[2].gu[0] = 32'd655360 + 32'd131072;
        vec[2].gu[1] = 32'd655360 + 32'd65536;
        vec[2].mask = 20'h00023; vec[2].n = 3; vec[2].mv = 32'd131072; vec[2].flag = 1;
        vec[2].r0 = 5; vec[2].s0 = 32'd66; vec[2].r1 = 6; vec[2].s1 = 32'd67;

        // 3: saturation both ways
        for (int i = 0; i < N; i++) begin
            vec[3].h[i] = 32'd655360; vec[3].gu[i] = 32'd0;
        end
        vec[3].h[0] = 32'h7FFF_FFFF; vec[3].gu[0] = 32'h8000_0000;
        vec[3].h[1] = 32'h8000_0000; vec[3].gu[1] = 32'h7FFF_FFFF;
        vec[3].mask = 20'h00002; vec[3].n = 1; vec[3].mv = 32'h7FFF_FFFF; vec[3].flag = 1;
        vec[3].r0 = 0; vec[3].s0 = 32'h7FFF_FFFF; vec[3].r1 = 1; vec[3].s1 = 32'h8000_0000;

        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        repeat (3) tick();
        ap_rst_n = 1'b1;
        tick();
        chk("rst idle", {31'd0, ap_idle}, 32'd1);
        chk("rst done", {31'd0, ap_done}, 32'd0);
        chk("rst reads", {30'd0, h_ce0, gu_ce0}, 32'd0);
        chk("rst write", {30'd0, s_ce0, s_we0}, 32'd0);
        chk("rst results", {7'd0, active_mask, n_active} | max_viol | {31'd0, viol_flag}, 32'd0);

        for (int k = 0; k < 4; k++) run_vec(k);

        // Back-to-back with start held high
        load(1);
        base = nwr;
        @(negedge ap_clk);
        ap_start = 1'b1;
        d1 = -1; d2 = -1;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (ap_done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    chk("b2b first n_active", {27'd0, n_active}, 32'd1);
                end else begin
                    d2 = cyc;
                    ap_start = 1'b0;
                    break;
                end
            end
            if (d1 >= 0 && cyc == d1 + 1) chk("b2b idle gap", {31'd0, ap_idle}, 32'd1);
            if (d1 >= 0 && cyc == d1 + 2) begin
                chk("b2b cleared n_active", {27'd0, n_active}, 32'd0);
                chk("b2b cleared max_viol", max_viol, 32'd0);
                chk("b2b running", {31'd0, ap_idle}, 32'd0);
            end
        end
        chk("b2b done spacing", d2 - d1, 23);
        chk("b2b writes", nwr - base, 2 * N);
        chk("b2b second max_viol", max_viol, 32'd65536);
        repeat (3) tick();
        chk("b2b stays idle", {31'd0, ap_idle}, 32'd1);

        // Reset in the middle of a run
        load(0);
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
        d1 = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (h_ce0 && h_address0 == 5'd10) begin d1 = 1; break; end
        end
        chk("midrst reached row 10", d1, 1);
        chk("midrst partial n_active", {27'd0, n_active}, 32'd9);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        base = nwr; dbase = done_cnt;
        repeat (30) tick();
        chk("midrst no writes", nwr - base, 0);
        chk("midrst no done", done_cnt - dbase, 0);
        chk("midrst idle", {31'd0, ap_idle}, 32'd1);
        chk("midrst mask", {12'd0, active_mask}, 32'd0);
        chk("midrst n_active", {27'd0, n_active}, 32'd0);
        run_vec(0);

        chk("address range", bad_addr, 0);
        chk("ready matches done", rdy_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
